lzc_denorm: RTL and testbench

Sequential denormalizer for Q16.16 values; it is the inverse of the leading-zero counter. It takes a normalized 32-bit mantissa and the leading-zero count that was stripped from it, and reconstructs the Q16.16 value by right-shifting the mantissa by that count, with round-half-up on the last bit shifted out. It sits after normalized-domain arithmetic (e.g. reciprocal/divide steps in the ray stepping path) and returns results to fixed point. It uses an iterative 4-bit-per-cycle shifter with valid/ready handshakes on both sides.

---
 rtl/lzc_denorm.sv | 147 ++++++++++++++
 tb/tb_lzc_denorm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_denorm.sv
// lzc_denorm
// Rebuilds a Q16.16 fixed-point value from a normalized mantissa and the
// leading-zero count removed from it. This is the inverse of the leading-zero
// counter. The mantissa is shifted right by the count, at most STEP bits per
// cycle. The last bit shifted out is kept as a guard bit and added back at the
// end, which gives round-half-up.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   reset_n  - asynchronous reset, active-low
//   i_valid  - request valid
//   o_ready  - block is idle and can accept a request
//   i_mant   - normalized mantissa; sampled only on acceptance
//   i_lzc    - shift count, legal range 0..32; sampled only on acceptance
//   o_valid  - result valid (registered)
//   i_ready  - downstream accepts the result
//   o_data   - Q16.16 result (registered)
//   o_err    - raised with o_valid when the request carried i_lzc > 32
module lzc_denorm #(
    parameter int STEP = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [31:0]   i_mant,
    input  logic [5:0]    i_lzc,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [15:-16] o_data,
    output logic          o_err
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] acc;
    logic [5:0]  rem;
    logic        guard;
    logic        err_flag;
    logic        accept;
    logic [5:0]  step_amt;
    logic [4:0]  guard_idx;

    assign o_ready = (state == IDLE);
    assign accept  = i_valid && o_ready;

    // The final partial step shifts only the remaining distance.
    assign step_amt  = (rem < STEP_W) ? rem : STEP_W;
    // This value is only used while rem != 0, so step_amt is at least 1 here.
    assign guard_idx = 5'(step_amt - 6'd1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (rem == 6'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: shifter, guard bit and registered result
    // An out-of-range count loads a zero accumulator with nothing left to
    // shift. The error result then takes the normal SHIFT->DONE path and
    // reads as 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            rem      <= '0;
            guard    <= 1'b0;
            err_flag <= 1'b0;
            o_data   <= '0;
            o_err    <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        guard <= 1'b0;
                        if (i_lzc <= 6'd32) begin
                            acc      <= i_mant;
                            rem      <= i_lzc;
                            err_flag <= 1'b0;
                        end else begin
                            acc      <= '0;
                            rem      <= '0;
                            err_flag <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (rem != 6'd0) begin
                        guard <= acc[guard_idx];
                        acc   <= acc >> step_amt;
                        rem   <= rem - step_amt;
                    end else begin
                        // This cannot overflow. After any shift the top bit
                        // of acc is clear. With no shift, guard is 0.
                        o_data  <= acc + {31'b0, guard};
                        o_err   <= err_flag;
                        o_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_denorm.sv
// tb_lzc_denorm
// Self-checking bench for lzc_denorm. It first applies a table of directed
// vectors. It then runs hand-written sequences for backpressure, reset in the
// middle of an operation, and back-to-back spacing. Finally it applies random
// requests and checks them against a reference model written in plain
// arithmetic.
module tb_lzc_denorm;

    logic          clk;
    logic          reset_n;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_mant;
    logic [5:0]    i_lzc;
    logic          o_valid;
    logic          i_ready;
    logic [15:-16] o_data;
    logic          o_err;

    int compared;
    int mismatched;
    int cycle;
    int accept_cycle;

    typedef struct {
        logic [31:0] mant;
        logic [5:0]  lzc;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_edges;
    } vec_t;

    vec_t vecs[8];

    lzc_denorm #(.STEP(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mant  (i_mant),
        .i_lzc   (i_lzc),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: the mantissa divided by 2^n and rounded half up, in
    // 64-bit arithmetic.
    function automatic logic [31:0] modelData(input logic [31:0] mant, input logic [5:0] lzc);
        logic [63:0] w;
        if (lzc > 6'd32) return 32'd0;
        if (lzc == 6'd0) return mant;
        w = {32'd0, mant} + (64'd1 << (lzc - 6'd1));
        return w[31:0] >> lzc | 32'((w >> 32) << (32 - int'(lzc)));
    endfunction

    function automatic int modelEdges(input logic [5:0] lzc);
        if (lzc > 6'd32) return 1;
        return (int'(lzc) + 3) / 4 + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Waits for o_ready, then holds i_valid for exactly one acceptance edge.
    // The task returns at the negedge after acceptance.
    task automatic sendRequest(input logic [31:0] mant, input logic [5:0] lzc);
        int waited;
        waited = 0;
        while (!o_ready && waited < 200) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_timeout", 32'(waited >= 200), 32'd0);
        i_valid = 1'b1;
        i_mant  = mant;
        i_lzc   = lzc;
        @(posedge clk);
        @(negedge clk);
        accept_cycle = cycle;
        i_valid = 1'b0;
        i_mant  = $urandom;
        i_lzc   = 6'($urandom);
    endtask

    // Counts rising edges after acceptance until o_valid is seen.
    task automatic waitResult(output int edges);
        edges = 0;
        while (!o_valid && edges < 100) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        checkOutput("valid_timeout", 32'(edges >= 100), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] mant, input logic [5:0] lzc, output int edges);
        sendRequest(mant, lzc);
        waitResult(edges);
    endtask

    initial begin
        int edges;
        int acc_at[3];
        logic [31:0] mant;
        logic [5:0]  lzc;

        compared   = 0;
        mismatched = 0;
        cycle      = 0;
        reset_n    = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_mant     = '0;
        i_lzc      = '0;

        vecs[0] = '{32'hC000_0000, 6'd16, 32'h0000_C000, 1'b0, 5};
        vecs[1] = '{32'h8000_0003, 6'd1,  32'h4000_0002, 1'b0, 2};
        vecs[2] = '{32'h8000_0002, 6'd1,  32'h4000_0001, 1'b0, 2};
        vecs[3] = '{32'h8000_0000, 6'd32, 32'h0000_0001, 1'b0, 9};
        vecs[4] = '{32'h0000_0000, 6'd32, 32'h0000_0000, 1'b0, 9};
        vecs[5] = '{32'hFFFF_FFFF, 6'd40, 32'h0000_0000, 1'b1, 1};
        vecs[6] = '{32'hA000_0000, 6'd3,  32'h1400_0000, 1'b0, 2};
        vecs[7] = '{32'hFFFF_FFFF, 6'd5,  32'h0800_0000, 1'b0, 3};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_o_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_o_data", o_data, 32'd0);
        checkOutput("reset_o_err", 32'(o_err), 32'd0);
        checkOutput("reset_o_ready", 32'(o_ready), 32'd1);

        // Identity shift held under backpressure. A stray request must be ignored.
        i_ready = 1'b0;
        applyStimulus(32'h8000_0000, 6'd0, edges);
        checkOutput("ident_edges", 32'(edges), 32'd1);
        checkOutput("ident_data", o_data, 32'h8000_0000);
        checkOutput("ident_err", 32'(o_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                i_valid = 1'b1;
                i_mant  = 32'h1234_5678;
                i_lzc   = 6'd3;
            end else begin
                i_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 32'(o_valid), 32'd1);
            checkOutput("hold_data", o_data, 32'h8000_0000);
            checkOutput("hold_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_valid", 32'(o_valid), 32'd0);
        checkOutput("release_ready", 32'(o_ready), 32'd1);
        checkOutput("release_data_kept", o_data, 32'h8000_0000);

        // Directed table. The error entry is followed by legal ones.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].mant, vecs[v].lzc, edges);
            checkOutput($sformatf("tbl%0d_data", v), o_data, vecs[v].exp_data);
            checkOutput($sformatf("tbl%0d_err", v), 32'(o_err), 32'(vecs[v].exp_err));
            checkOutput($sformatf("tbl%0d_edges", v), 32'(edges), 32'(vecs[v].exp_edges));
        end

        // Reset during SHIFT aborts the request.
        sendRequest(32'h8000_0000, 6'd32);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(o_ready), 32'd1);
        checkOutput("midreset_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_valid) edges++;
        end
        checkOutput("midreset_no_valid", 32'(edges), 32'd0);
        checkOutput("midreset_idle", 32'(o_ready), 32'd1);

        // Back-to-back stream with i_ready held high. Spacing is k+3.
        applyStimulus(32'hC000_0000, 6'd16, edges);
        acc_at[0] = accept_cycle;
        checkOutput("stream0_data", o_data, 32'h0000_C000);
        applyStimulus(32'h8000_0000, 6'd32, edges);
        acc_at[1] = accept_cycle;
        checkOutput("stream1_data", o_data, 32'h0000_0001);
        applyStimulus(32'hF000_0000, 6'd5, edges);
        acc_at[2] = accept_cycle;
        checkOutput("stream2_data", o_data, 32'h0780_0000);
        checkOutput("stream_gap0", 32'(acc_at[1] - acc_at[0]), 32'd7);
        checkOutput("stream_gap1", 32'(acc_at[2] - acc_at[1]), 32'd11);

        // Random requests checked against the model.
        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(0, 3))
                0:       mant = $urandom;
                1:       mant = $urandom | 32'h8000_0000;
                2:       mant = 32'hFFFF_FFFF;
                default: mant = 32'd0;
            endcase
            lzc = 6'($urandom_range(0, 40));
            applyStimulus(mant, lzc, edges);
            checkOutput($sformatf("rnd%0d_data(m=%08h n=%0d)", r, mant, lzc), o_data, modelData(mant, lzc));
            checkOutput($sformatf("rnd%0d_err", r), 32'(o_err), 32'(lzc > 6'd32));
            checkOutput($sformatf("rnd%0d_edges", r), 32'(edges), 32'(modelEdges(lzc)));
        end
        @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
